// File: rtl/decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_sequencer
// Purpose  : Steps a 3-bit channel code {a,b,c} through the enabled channels
//            of an 8-bit mask, holding each code for a programmable dwell.
//            Supports single-sweep and continuous (wrap) modes plus stop.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               active,
    output logic               step,
    output logic               done
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_dwell = 1'b1;

    logic [0:0]         r_state;
    logic [2:0]         r_code;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_mode;
    logic               r_active;
    logic               r_step;
    logic               r_done;

    logic [2:0]         w_low_code;
    logic               w_low_found;
    logic [2:0]         w_next_code;
    logic               w_next_found;
    logic [DWELL_W-1:0] w_dwell_load;

    // Priority search of the live mask: lowest set bit overall, and lowest
    // set bit strictly above the code currently being driven.
    always_comb begin
        w_low_code   = 3'd0;
        w_low_found  = 1'b0;
        w_next_code  = 3'd0;
        w_next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                w_low_code  = 3'(i);
                w_low_found = 1'b1;
            end
            if (mask[i] && (i > int'(r_code))) begin
                w_next_code  = 3'(i);
                w_next_found = 1'b1;
            end
        end
    end

    // A dwell of zero behaves as one cycle; the counter holds cycles-1.
    assign w_dwell_load = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

    // Scan state machine with registered outputs; step/done are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_code   <= 3'd0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_active <= 1'b0;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start && !stop) begin
                        r_mode <= mode;
                        if (w_low_found) begin
                            r_state  <= c_st_dwell;
                            r_code   <= w_low_code;
                            r_active <= 1'b1;
                            r_step   <= 1'b1;
                            r_cnt    <= w_dwell_load;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        r_state  <= c_st_idle;
                        r_code   <= 3'd0;
                        r_active <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end else if (w_next_found) begin
                        r_code <= w_next_code;
                        r_step <= 1'b1;
                        r_cnt  <= w_dwell_load;
                    end else if (r_mode && w_low_found) begin
                        r_code <= w_low_code;
                        r_step <= 1'b1;
                        r_cnt  <= w_dwell_load;
                    end else begin
                        r_state  <= c_st_idle;
                        r_code   <= 3'd0;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign a      = r_code[2];
    assign b      = r_code[1];
    assign c      = r_code[0];
    assign active = r_active;
    assign step   = r_step;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan_sequencer
// Purpose  : Directed and randomized checking of decoder_scan_sequencer
//            against a channel-list / remaining-hold reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] dwell = 8'h00;
    logic       a, b, c, active, step, done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: channel being driven and cycles of hold left.
    bit m_busy = 1'b0;
    int m_code = 0;
    int m_hold = 0;
    bit m_mode = 1'b0;
    bit m_step = 1'b0;
    bit m_done = 1'b0;

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .mask   (mask),
        .dwell  (dwell),
        .a      (a),
        .b      (b),
        .c      (c),
        .active (active),
        .step   (step),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Smallest enabled channel number greater than 'after', or -1.
    function automatic int first_after(logic [7:0] m, int after);
        for (int i = 0; i < 8; i++)
            if (i > after && m[i]) return i;
        return -1;
    endfunction

    function automatic int hold_of(logic [7:0] d);
        return (d == 8'd0) ? 1 : int'(d);
    endfunction

    function automatic logic [5:0] vec(int code, bit act, bit stp, bit dn);
        return {3'(code), act, stp, dn};
    endfunction

    function automatic logic [5:0] outv();
        return {a, b, c, active, step, done};
    endfunction

    task automatic check(string name, logic [5:0] got, logic [5:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got {abc,act,step,done}=%b expected %b",
                     name, $time, got, want);
        end
    endtask

    // Advance the model across one clock edge using the inputs held stable.
    task automatic model_edge();
        int nxt;
        m_step = 1'b0;
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_code = 0; m_hold = 0; m_mode = 1'b0;
        end else if (!m_busy) begin
            if (start && !stop) begin
                m_mode = mode;
                if (mask != 8'h00) begin
                    m_busy = 1'b1;
                    m_code = first_after(mask, -1);
                    m_hold = hold_of(dwell);
                    m_step = 1'b1;
                end else begin
                    m_done = 1'b1;
                end
            end
        end else if (stop) begin
            m_busy = 1'b0; m_code = 0;
        end else begin
            m_hold--;
            if (m_hold == 0) begin
                nxt = first_after(mask, m_code);
                if (nxt < 0 && m_mode) nxt = first_after(mask, -1);
                if (nxt >= 0) begin
                    m_code = nxt; m_hold = hold_of(dwell); m_step = 1'b1;
                end else begin
                    m_busy = 1'b0; m_code = 0; m_done = 1'b1;
                end
            end
        end
    endtask

    // One clock: update the model at the edge, compare shortly after.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model", outv(), vec(m_code, m_busy, m_step, m_done));
    endtask

    initial begin
        int cseq[4];
        cseq = '{0, 2, 5, 7};

        // Reset with start held high: nothing may start.
        rst_n = 1'b0; start = 1'b1; mask = 8'hFF; dwell = 8'd3;
        tick(); tick();
        check("reset_state", outv(), vec(0, 0, 0, 0));

        // Single sweep over 0xA5, dwell 3.
        rst_n = 1'b1; start = 1'b0; mask = 8'hA5; dwell = 8'd3; mode = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            check("a5_seq", outv(), vec(cseq[k / 3], 1, (k % 3) == 0, 0));
        end
        tick(); check("a5_done", outv(), vec(0, 0, 0, 1));
        tick(); check("a5_idle", outv(), vec(0, 0, 0, 0));

        // Continuous 0x81 with dwell 0: alternate every cycle until stop.
        mask = 8'h81; dwell = 8'd0; mode = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            check("w81_seq", outv(), vec((k % 2) ? 7 : 0, 1, 1, 0));
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check("w81_stop", outv(), vec(0, 0, 0, 0));
        tick(); check("w81_nodone", outv(), vec(0, 0, 0, 0));

        // Empty mask start request.
        mask = 8'h00; mode = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        check("empty_done", outv(), vec(0, 0, 0, 1));
        tick(); check("empty_idle", outv(), vec(0, 0, 0, 0));

        // Clear bit 5 while channel 2 is driven: no channel 5 visit.
        mask = 8'h24; dwell = 8'd4; start = 1'b1;
        tick(); start = 1'b0;
        check("m24_first", outv(), vec(2, 1, 1, 0));
        mask = 8'h04; tick();
        check("m24_hold", outv(), vec(2, 1, 0, 0));
        tick(); tick();
        check("m24_hold4", outv(), vec(2, 1, 0, 0));
        tick(); check("m24_done", outv(), vec(0, 0, 0, 1));

        // Replace bit 5 by bit 7 while channel 2 is driven.
        mask = 8'h24; start = 1'b1;
        tick(); start = 1'b0; mask = 8'h84;
        tick(); tick(); tick(); tick();
        check("m84_ch7", outv(), vec(7, 1, 1, 0));
        tick(); tick(); tick(); tick();
        check("m84_done", outv(), vec(0, 0, 0, 1));

        // Reset mid-scan on channel 5 with start held high.
        mask = 8'h24; dwell = 8'd3; mode = 1'b1; start = 1'b1;
        tick(); tick(); tick(); tick();
        check("rst_ch5", outv(), vec(5, 1, 1, 0));
        tick();
        rst_n = 1'b0; tick();
        check("rst_mid", outv(), vec(0, 0, 0, 0));
        rst_n = 1'b1; start = 1'b0; tick();
        check("rst_stay", outv(), vec(0, 0, 0, 0));
        start = 1'b1; tick(); start = 1'b0;
        check("rst_restart", outv(), vec(2, 1, 1, 0));
        stop = 1'b1; tick(); stop = 1'b0;

        // Single-channel continuous scan, then stop against start.
        mask = 8'h10; dwell = 8'd2; mode = 1'b1;
        start = 1'b1; stop = 1'b1; tick();
        check("idle_stop_wins", outv(), vec(0, 0, 0, 0));
        stop = 1'b0; tick(); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            check("single_seq", outv(), vec(4, 1, (k % 2) == 0, 0));
        end
        start = 1'b1; stop = 1'b1; tick();
        check("single_stop", outv(), vec(0, 0, 0, 0));
        start = 1'b0; stop = 1'b0; tick();
        check("single_idle", outv(), vec(0, 0, 0, 0));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom % 200) != 0;
            start = ($urandom % 8) == 0;
            stop  = ($urandom % 40) == 0;
            mode  = 1'($urandom % 2);
            if (($urandom % 10) == 0) mask = 8'($urandom);
            if (($urandom % 4) == 0)
                dwell = (($urandom % 30) == 0) ? 8'hFF : 8'($urandom % 6);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
Upstream driver for the 3-to-8 decoder. It steps a 3-bit channel code {a,b,c} through the enabled channels of an 8-bit mask, holding each code for a programmable dwell time. It supports single-sweep and continuous modes and a start/stop control. The decoder consumes a, b, c directly; `active` qualifies the decoder outputs.

Parameters:
DWELL_W, 8, width of the dwell-time input in bits

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  begin a scan; sampled in IDLE only
stop  input  1  abort the scan; has priority over start
mode  input  1  0 = single sweep, 1 = continuous (wrap); latched when start is accepted
mask  input  8  channel enables, bit i = channel i; read live every cycle
dwell  input  DWELL_W  cycles per channel; 0 is treated as 1; sampled at each channel load
a  output  1  channel code MSB (code[2])
b  output  1  channel code bit 1
c  output  1  channel code LSB (code[0])
active  output  1  high while a channel is being driven
step  output  1  one-cycle pulse in the first cycle of each channel, including the first channel
done  output  1  one-cycle pulse when a sweep completes or the start request is empty

Behaviour:
- Reset (rst_n low at a clock edge): state = IDLE; a, b, c, active, step, done all 0; dwell counter 0; latched mode 0. Reset overrides start and stop.
- States: IDLE, DWELL.
- IDLE: code = 000, active = 0.
  - start=1, stop=0, mask != 0: at the next edge go to DWELL. Code = lowest set bit of mask, active=1, step=1. Counter = max(dwell,1) - 1.
  - start=1, stop=0, mask == 0: stay in IDLE, done=1 for one cycle.
- DWELL: the counter decrements each cycle. The current code is held for exactly max(dwell,1) cycles.
  - When the counter is 0 at an edge, search mask for the lowest set bit strictly above the current code.
    - Found: load that code, step=1, reload the counter.
    - Not found, latched mode=1, mask != 0: wrap to the lowest set bit, step=1, reload the counter.
    - Not found, and (mode=0 or mask == 0): go to IDLE. Code = 000, active=0, done=1 for one cycle.
  - stop=1: at the next edge go to IDLE. Code = 000, active=0, done=0, step=0.
  - start is ignored while in DWELL.
- Mask changes mid-dwell do not cut the current channel short. They affect only the next search.
- A channel whose mask bit is cleared while it is being driven still completes its dwell.
- Single-channel continuous scan (one mask bit set, mode=1): the code stays constant and step pulses every max(dwell,1) cycles.
- Latency: start accepted at edge T0 gives active=1 and the first code valid after T0.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- The counter is DWELL_W bits wide. dwell = all-ones gives a hold of 2^DWELL_W - 1 cycles.

Test Plan:
- mask=8'hA5, dwell=3, mode=0, 1-cycle start pulse sampled at edge T0 -> codes 0, 2, 5, 7, each 3 cycles, step at T0, T3, T6, T9. At edge T12: active=0, code=000, done=1 for one cycle.
- mask=8'h81, dwell=0, mode=1 -> code alternates 0, 7, 0, 7 every cycle with step=1 every cycle, until stop. After stop: next cycle active=0, done never asserted.
- mask=8'h00, start -> done=1 one cycle later; active and step stay 0; code stays 000.
- mask=8'h24, dwell=4, mode=0; clear bit 5 during channel 2 -> channel 2 holds 4 cycles, then done=1 with no channel 5 visit. Set bit 7 instead -> channel 7 is visited after channel 2.
- Reset mid-scan on channel 5 with start held high -> after the reset edge all outputs are 0. No scan restarts until start is seen with rst_n=1.
- Single channel mask=8'h10, dwell=2, mode=1 -> code 100 constant, step every 2 cycles. stop and start asserted together -> stop wins, IDLE next cycle.
